sdr_xfr_responder: RTL and testbench
====================================

# sdr_xfr_responder

Memory-side responder for the SDRAM bus-width converter's transfer interface. It drives the narrow-beat handshake strobes toward the converter, collects 8/16/32-bit write beats into 32-bit words in a small internal store, and returns read words as 8/16/32-bit beats. It is the synthesizable far end of the width-conversion path. It lets the converter be exercised in all three `sdr_width` modes without the SDRAM core attached.

## Interface
- `DEPTH`, 16: words in internal store; power of two.
- `AW`, 4: address width, log2(DEPTH).
- `clk` input 1: single clock; all logic on rising edge.
- `reset` input 1: asynchronous, active-high.
- `sdr_width` input 2: width mode. 00 = 32-bit, 1 beat/word. 01 = 16-bit, 2 beats/word. 1x = 8-bit, 4 beats/word. Sampled at request accept.
- `wr_req` input 1: write request.
- `rd_req` input 1: read request.
- `xfr_addr` input AW: start word address.
- `xfr_len` input 3: word count minus 1, giving 1..8 words.
- `req_ack` output 1: request accepted this cycle.
- `busy` output 1: transfer in progress.
- `a2x_wrdt` input 32: write beat from converter. Valid bits are [7:0], [15:0] or [31:0] according to mode.
- `x2a_wrstart` output 1: first write beat.
- `x2a_wrnext` output 1: write beat strobe. `a2x_wrdt` is sampled in the same cycle.
- `x2a_wrlast` output 1: last write beat.
- `x2a_rddt` output 32: read beat. Unused upper bits are 0.
- `x2a_rdstart` output 1: first read beat.
- `x2a_rdok` output 1: read beat valid.
- `x2a_rdlast` output 1: last read beat.

## Operation
- **States:** IDLE, WR, RD, plus GAP when `SDR_RESP_GAP_EN` is defined.
- **Accept (IDLE):**
  - `req_ack` = IDLE & (`wr_req` | `rd_req`), combinational.
  - `wr_req` has priority when both requests are high; the read is dropped and must be re-requested.
  - Requests outside IDLE are ignored.
- **Captured at accept:** `sdr_width`, `xfr_addr` and `xfr_len` are registered and held for the whole transfer. Mid-transfer changes have no effect.
- **Counters:**
  - Beat counter is 2 bits; it wraps at beats-per-word minus 1.
  - Word counter counts 0..`xfr_len`.
  - Word address = start + word index, modulo DEPTH (wraps 15→0 at DEPTH=16).
- **Beat order is LSB first:**
  - 16-bit: [15:0] then [31:16].
  - 8-bit: [7:0], [15:8], [23:16], [31:24].
- **Write path:**
  - Each `x2a_wrnext` cycle shifts the low beat bits of `a2x_wrdt` into an assembly register at the lane selected by the beat counter.
  - On the final beat of a word, the full word is written to the store.
  - A partially assembled word is never committed.
- **Read path:**
  - The word is read from the store and sliced by the beat counter.
  - `x2a_rddt` carries the slice right-justified, with upper bits zero.
- **Strobes:**
  - `x2a_wrstart` / `x2a_rdstart` are high only with the first beat of the transfer.
  - `x2a_wrlast` / `x2a_rdlast` are high only with the last beat.
  - For a single-beat transfer, start and last are both high in the same cycle.
- **Return to IDLE:** after the last beat, the state returns to IDLE and `busy` drops on the next edge.
- **Reset:**
  - All outputs are 0, the state is IDLE and the counters are cleared.
  - This applies immediately on assertion, including mid-transfer. The in-flight partial word is discarded.
  - Store contents are not reset; words already committed are retained.

## Timing
- Request accepted at cycle T. The first beat (`wrnext` / `rdok`) is at T+1.
- Beats are contiguous: N = (xfr_len+1) × beats-per-word, occupying T+1..T+N.
- `busy` is high T+1..T+N. The next accept is possible at T+N+1.
- `x2a_rddt` and all strobes are registered.
- Write data is sampled at the edge that ends a `wrnext` cycle.
- A committed word is readable by a request accepted the cycle after `wrlast`.

## Configuration
- **`SDR_RESP_GAP_EN` defined:**
  - After the last beat of each word except the final one, the block spends one cycle in GAP.
  - In GAP all strobes are 0 and the counters hold.
  - N becomes beats + xfr_len cycles. This models SDRAM column gaps and checks that the converter tolerates non-contiguous beats.
- **`SDR_RESP_GAP_EN` undefined:** GAP state and its logic are absent, and beats are strictly contiguous.

## Test plan
- **32-bit write, then read:** write addr 3, len 0, data 0xDEADBEEF.
  - One `wrnext` cycle with `wrstart` = `wrlast` = 1.
  - Read of addr 3 gives one `rdok` with `x2a_rddt` = 0xDEADBEEF and `rdstart` = `rdlast` = 1.
- **16-bit write, 2 words:** 0x11112222 and 0x33334444 at addr 0.
  - `a2x_wrdt` sampled over 4 beats as 0x2222, 0x1111, 0x4444, 0x3333; `wrlast` on beat 4.
  - 16-bit readback gives the same beat sequence with bits [31:16] = 0.
- **8-bit read:** word 0xA1B2C3D4.
  - Beats 0xD4, 0xC3, 0xB2, 0xA1; `rdlast` only on the 4th.
  - Reading the same word in 32-bit mode returns 0xA1B2C3D4.
- **Address wrap (DEPTH = 16):** write addr 15, len 1.
  - Words land at 15 and 0.
  - A 32-bit read of addr 0 returns the second word.
- **Reset mid-transfer:** assert `reset` after beat 2 of an 8-bit write to addr 5.
  - All strobes and `busy` go to 0 at once.
  - After release, addr 5 still holds its prior value, and a new request gets `req_ack` on its first cycle.
- **Simultaneous requests and gap mode:**
  - `wr_req` and `rd_req` together in IDLE: a write is performed and no `rdok` occurs.
  - With `SDR_RESP_GAP_EN` defined, a 2-word 32-bit read gives `rdok` at T+1 and T+3, with T+2 idle.

Source files
------------

// File: rtl/sdr_xfr_responder_if.sv
// Transfer-interface bundle between the SDRAM bus-width converter (master)
// and the memory-side responder (slave).
interface sdr_xfr_responder_if #(
  parameter int AW = 4
);
  logic [1:0]    sdr_width;
  logic          wr_req;
  logic          rd_req;
  logic [AW-1:0] xfr_addr;
  logic [2:0]    xfr_len;
  logic          req_ack;
  logic          busy;
  logic [31:0]   a2x_wrdt;
  logic          x2a_wrstart;
  logic          x2a_wrnext;
  logic          x2a_wrlast;
  logic [31:0]   x2a_rddt;
  logic          x2a_rdstart;
  logic          x2a_rdok;
  logic          x2a_rdlast;

  modport master (
    output sdr_width, wr_req, rd_req, xfr_addr, xfr_len, a2x_wrdt,
    input  req_ack, busy, x2a_wrstart, x2a_wrnext, x2a_wrlast,
    input  x2a_rddt, x2a_rdstart, x2a_rdok, x2a_rdlast
  );

  modport slave (
    input  sdr_width, wr_req, rd_req, xfr_addr, xfr_len, a2x_wrdt,
    output req_ack, busy, x2a_wrstart, x2a_wrnext, x2a_wrlast,
    output x2a_rddt, x2a_rdstart, x2a_rdok, x2a_rdlast
  );
endinterface

// File: rtl/sdr_xfr_responder.sv
// Memory-side responder for the SDRAM width converter: packs 8/16/32-bit beats into
// a small word store and returns words as beats. Define SDR_RESP_GAP_EN for inter-word gaps.
module sdr_xfr_responder #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input logic               clk,
  input logic               reset,
  sdr_xfr_responder_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2
`ifdef SDR_RESP_GAP_EN
    , ST_GAP = 2'd3
`endif
  } state_t;

  // Index of the last beat in a word for a given width mode.
  function automatic logic [1:0] beat_max(input logic [1:0] width);
    logic [1:0] res;
    case (width)
      2'b00:   res = 2'd0;
      2'b01:   res = 2'd1;
      default: res = 2'd3;
    endcase
    return res;
  endfunction

  // Insert the low beat bits of data into the lane of old picked by beat.
  function automatic logic [31:0] merge_beat(input logic [31:0] old, input logic [31:0] data,
                                             input logic [1:0] width, input logic [1:0] beat);
    logic [31:0] res;
    res = old;
    case (width)
      2'b00: res = data;
      2'b01: begin
        if (beat[0]) res[31:16] = data[15:0];
        else         res[15:0]  = data[15:0];
      end
      default: begin
        case (beat)
          2'd0:    res[7:0]   = data[7:0];
          2'd1:    res[15:8]  = data[7:0];
          2'd2:    res[23:16] = data[7:0];
          default: res[31:24] = data[7:0];
        endcase
      end
    endcase
    return res;
  endfunction

  // Right-justified lane of word selected by beat, upper bits zero.
  function automatic logic [31:0] slice_beat(input logic [31:0] word, input logic [1:0] width,
                                             input logic [1:0] beat);
    logic [31:0] res;
    case (width)
      2'b00: res = word;
      2'b01: res = beat[0] ? {16'h0000, word[31:16]} : {16'h0000, word[15:0]};
      default: begin
        case (beat)
          2'd0:    res = {24'h000000, word[7:0]};
          2'd1:    res = {24'h000000, word[15:8]};
          2'd2:    res = {24'h000000, word[23:16]};
          default: res = {24'h000000, word[31:24]};
        endcase
      end
    endcase
    return res;
  endfunction

  state_t        state_r, state_s;
  logic [1:0]    width_r, width_s;
  logic [AW-1:0] addr_r, addr_s;
  logic [2:0]    len_r, len_s;
  logic [1:0]    beat_r, beat_s;
  logic [2:0]    word_r, word_s;
`ifdef SDR_RESP_GAP_EN
  logic          dir_wr_r, dir_wr_s;
`endif

  logic [31:0]   asm_r;
  logic [31:0]   asm_s;
  logic          commit_s;
  logic [AW-1:0] waddr_s;
  logic [AW-1:0] raddr_s;
  logic [31:0]   mem_r [DEPTH];

  logic          busy_r, busy_s;
  logic          wrstart_r, wrstart_s;
  logic          wrnext_r, wrnext_s;
  logic          wrlast_r, wrlast_s;
  logic          rdstart_r, rdstart_s;
  logic          rdok_r, rdok_s;
  logic          rdlast_r, rdlast_s;
  logic [31:0]   rddt_r, rddt_s;
  logic          first_s, last_s;

  // Reset gates the combinational acknowledge so every output reads 0 while it is held.
  assign bus.req_ack     = (state_r == ST_IDLE) && (bus.wr_req || bus.rd_req) && !reset;
  assign bus.busy        = busy_r;
  assign bus.x2a_wrstart = wrstart_r;
  assign bus.x2a_wrnext  = wrnext_r;
  assign bus.x2a_wrlast  = wrlast_r;
  assign bus.x2a_rddt    = rddt_r;
  assign bus.x2a_rdstart = rdstart_r;
  assign bus.x2a_rdok    = rdok_r;
  assign bus.x2a_rdlast  = rdlast_r;

  // Next-state and counter logic; counters describe the beat presented in the next cycle.
  always_comb begin
    state_s = state_r;
    width_s = width_r;
    addr_s  = addr_r;
    len_s   = len_r;
    beat_s  = beat_r;
    word_s  = word_r;
`ifdef SDR_RESP_GAP_EN
    dir_wr_s = dir_wr_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (bus.wr_req || bus.rd_req) begin
          state_s = bus.wr_req ? ST_WR : ST_RD;
          width_s = bus.sdr_width;
          addr_s  = bus.xfr_addr;
          len_s   = bus.xfr_len;
          beat_s  = 2'd0;
          word_s  = 3'd0;
`ifdef SDR_RESP_GAP_EN
          dir_wr_s = bus.wr_req;
`endif
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WR, ST_RD: begin
        if (beat_r == beat_max(width_r)) begin
          beat_s = 2'd0;
          if (word_r == len_r) begin
            state_s = ST_IDLE;
            word_s  = 3'd0;
          end else begin
            word_s = word_r + 3'd1;
`ifdef SDR_RESP_GAP_EN
            state_s = ST_GAP;
`endif
          end
        end else begin
          beat_s = beat_r + 2'd1;
        end
      end
`ifdef SDR_RESP_GAP_EN
      ST_GAP: begin
        state_s = dir_wr_r ? ST_WR : ST_RD;
      end
`endif
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Registered strobes and read data derived from the upcoming beat position.
  always_comb begin
    first_s   = (beat_s == 2'd0) && (word_s == 3'd0);
    last_s    = (beat_s == beat_max(width_s)) && (word_s == len_s);
    raddr_s   = addr_s + AW'(word_s);
    busy_s    = (state_s != ST_IDLE);
    wrnext_s  = (state_s == ST_WR);
    wrstart_s = wrnext_s && first_s;
    wrlast_s  = wrnext_s && last_s;
    rdok_s    = (state_s == ST_RD);
    rdstart_s = rdok_s && first_s;
    rdlast_s  = rdok_s && last_s;
    if (rdok_s) begin
      rddt_s = slice_beat(mem_r[raddr_s], width_s, beat_s);
    end else begin
      rddt_s = 32'h0000_0000;
    end
  end

  // Write assembly: the beat on the bus in a WR cycle completes the word on its final lane.
  always_comb begin
    asm_s    = merge_beat(asm_r, bus.a2x_wrdt, width_r, beat_r);
    waddr_s  = addr_r + AW'(word_r);
    commit_s = (state_r == ST_WR) && (beat_r == beat_max(width_r));
  end

  // FSM, transfer context and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      width_r   <= 2'b00;
      addr_r    <= '0;
      len_r     <= 3'd0;
      beat_r    <= 2'd0;
      word_r    <= 3'd0;
`ifdef SDR_RESP_GAP_EN
      dir_wr_r  <= 1'b0;
`endif
      asm_r     <= 32'h0000_0000;
      busy_r    <= 1'b0;
      wrstart_r <= 1'b0;
      wrnext_r  <= 1'b0;
      wrlast_r  <= 1'b0;
      rdstart_r <= 1'b0;
      rdok_r    <= 1'b0;
      rdlast_r  <= 1'b0;
      rddt_r    <= 32'h0000_0000;
    end else begin
      state_r   <= state_s;
      width_r   <= width_s;
      addr_r    <= addr_s;
      len_r     <= len_s;
      beat_r    <= beat_s;
      word_r    <= word_s;
`ifdef SDR_RESP_GAP_EN
      dir_wr_r  <= dir_wr_s;
`endif
      if (state_r == ST_WR) begin
        asm_r <= asm_s;
      end
      busy_r    <= busy_s;
      wrstart_r <= wrstart_s;
      wrnext_r  <= wrnext_s;
      wrlast_r  <= wrlast_s;
      rdstart_r <= rdstart_s;
      rdok_r    <= rdok_s;
      rdlast_r  <= rdlast_s;
      rddt_r    <= rddt_s;
    end
  end

  // Word store; deliberately not reset so committed words survive a reset.
  always_ff @(posedge clk) begin
    if (commit_s) begin
      mem_r[waddr_s] <= asm_s;
    end
  end

endmodule

// File: tb/tb_sdr_xfr_responder.sv
// Self-checking bench for sdr_xfr_responder: table of write/read transfers with a
// read-beat scoreboard, plus hand-written reset and simultaneous-request sequences.
module tb_sdr_xfr_responder;

  typedef struct packed {
    logic        is_wr;
    logic [1:0]  width;
    logic [3:0]  addr;
    logic [2:0]  len;
    logic [31:0] w0;
    logic [31:0] w1;
  } vec_t;

  typedef struct packed {
    logic [31:0] d;
    logic        s;
    logic        l;
  } rbeat_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  rbeat_t rq[$];
  rbeat_t mon_e;
  vec_t   vecs[14];

  always #5 clk = ~clk;

  sdr_xfr_responder_if #(.AW(4)) bus ();

  sdr_xfr_responder #(.DEPTH(16), .AW(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int bpw(input logic [1:0] w);
    return (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] lane_mask(input logic [1:0] w);
    return (w == 2'b00) ? 32'hFFFF_FFFF : (w == 2'b01) ? 32'h0000_FFFF : 32'h0000_00FF;
  endfunction

  function automatic logic [31:0] beat_of(input logic [31:0] word, input logic [1:0] w, input int b);
    logic [31:0] sh;
    sh = (w == 2'b00) ? word : (w == 2'b01) ? (word >> (16 * b)) : (word >> (8 * b));
    return sh & lane_mask(w);
  endfunction

  function automatic logic [31:0] word_of(input vec_t v, input int i);
    if (i == 0) return v.w0;
    if (i == 1) return v.w1;
    return v.w0 + 32'(i) * 32'h0101_0101;
  endfunction

  // Every rdok beat must match the oldest expected beat.
  always @(negedge clk) begin
    if (bus.x2a_rdok === 1'b1) begin
      if (rq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rdok: rddt=%0h with no read outstanding at %0t", bus.x2a_rddt, $time);
      end else begin
        mon_e = rq.pop_front();
        chk("rd_beat", {31'd0, bus.x2a_rddt, bus.x2a_rdstart, bus.x2a_rdlast},
            {31'd0, mon_e.d, mon_e.s, mon_e.l});
      end
    end
  end

  task automatic scramble_req_fields();
    bus.sdr_width = 2'($urandom_range(3, 0));
    bus.xfr_addr  = 4'($urandom_range(15, 0));
    bus.xfr_len   = 3'($urandom_range(7, 0));
  endtask

  task automatic run_write(input vec_t v, input logic both);
    int nb;
    int n;
    int k;
    logic [31:0] junk;
    nb = bpw(v.width);
    n  = (int'(v.len) + 1) * nb;
    k  = 0;
    @(negedge clk);
    bus.sdr_width = v.width;
    bus.xfr_addr  = v.addr;
    bus.xfr_len   = v.len;
    bus.wr_req    = 1'b1;
    bus.rd_req    = both;
    #1;
    chk("wr_ack", {63'd0, bus.req_ack}, 64'd1);
    @(negedge clk);
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
    scramble_req_fields();
    for (int w = 0; w <= int'(v.len); w++) begin
      for (int b = 0; b < nb; b++) begin
        junk = $urandom;
        bus.a2x_wrdt = beat_of(word_of(v, w), v.width, b) | (junk & ~lane_mask(v.width));
        bus.rd_req = (k == 1);
        #1;
        chk("wr_strobes",
            {59'd0, bus.x2a_wrnext, bus.x2a_wrstart, bus.x2a_wrlast, bus.busy, bus.req_ack},
            {59'd0, 1'b1, k == 0, k == n - 1, 1'b1, 1'b0});
        @(negedge clk);
        bus.rd_req = 1'b0;
        k++;
`ifdef SDR_RESP_GAP_EN
        if (b == nb - 1 && w != int'(v.len)) begin
          #1;
          chk("wr_gap", {60'd0, bus.x2a_wrnext, bus.x2a_wrstart, bus.x2a_wrlast, bus.busy},
              {60'd0, 4'b0001});
          @(negedge clk);
        end
`endif
      end
    end
    #1;
    chk("wr_done", {62'd0, bus.x2a_wrnext, bus.busy}, 64'd0);
  endtask

  task automatic run_read(input vec_t v);
    int nb;
    int n;
    int k;
    rbeat_t e;
    nb = bpw(v.width);
    n  = (int'(v.len) + 1) * nb;
    k  = 0;
    @(negedge clk);
    bus.sdr_width = v.width;
    bus.xfr_addr  = v.addr;
    bus.xfr_len   = v.len;
    bus.rd_req    = 1'b1;
    #1;
    chk("rd_ack", {63'd0, bus.req_ack}, 64'd1);
    for (int w = 0; w <= int'(v.len); w++) begin
      for (int b = 0; b < nb; b++) begin
        e.d = beat_of(word_of(v, w), v.width, b);
        e.s = (w == 0 && b == 0);
        e.l = (w == int'(v.len) && b == nb - 1);
        rq.push_back(e);
      end
    end
    @(negedge clk);
    bus.rd_req = 1'b0;
    scramble_req_fields();
    for (int w = 0; w <= int'(v.len); w++) begin
      for (int b = 0; b < nb; b++) begin
        bus.wr_req = (k == 1);
        #1;
        chk("rd_timing", {61'd0, bus.x2a_rdok, bus.busy, bus.req_ack}, {61'd0, 3'b110});
        @(negedge clk);
        bus.wr_req = 1'b0;
        k++;
`ifdef SDR_RESP_GAP_EN
        if (b == nb - 1 && w != int'(v.len)) begin
          #1;
          chk("rd_gap", {62'd0, bus.x2a_rdok, bus.busy}, {62'd0, 2'b01});
          @(negedge clk);
        end
`endif
      end
    end
    #1;
    chk("rd_done", {29'd0, bus.x2a_rddt, bus.x2a_rdok, bus.busy, rq.size() == 0},
        {29'd0, 32'h0, 3'b001});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b1, 2'b00, 4'd3,  3'd0, 32'hDEAD_BEEF, 32'h0000_0000};
    vecs[1]  = '{1'b0, 2'b00, 4'd3,  3'd0, 32'hDEAD_BEEF, 32'h0000_0000};
    vecs[2]  = '{1'b0, 2'b11, 4'd3,  3'd0, 32'hDEAD_BEEF, 32'h0000_0000};
    vecs[3]  = '{1'b1, 2'b01, 4'd0,  3'd1, 32'h1111_2222, 32'h3333_4444};
    vecs[4]  = '{1'b0, 2'b01, 4'd0,  3'd1, 32'h1111_2222, 32'h3333_4444};
    vecs[5]  = '{1'b1, 2'b00, 4'd7,  3'd0, 32'hA1B2_C3D4, 32'h0000_0000};
    vecs[6]  = '{1'b0, 2'b10, 4'd7,  3'd0, 32'hA1B2_C3D4, 32'h0000_0000};
    vecs[7]  = '{1'b0, 2'b00, 4'd7,  3'd0, 32'hA1B2_C3D4, 32'h0000_0000};
    vecs[8]  = '{1'b1, 2'b00, 4'd8,  3'd7, 32'h1020_3040, 32'h55AA_55AA};
    vecs[9]  = '{1'b0, 2'b10, 4'd8,  3'd7, 32'h1020_3040, 32'h55AA_55AA};
    vecs[10] = '{1'b1, 2'b10, 4'd15, 3'd1, 32'hCAFE_F00D, 32'h0BAD_C0DE};
    vecs[11] = '{1'b0, 2'b00, 4'd0,  3'd0, 32'h0BAD_C0DE, 32'h0000_0000};
    vecs[12] = '{1'b0, 2'b01, 4'd15, 3'd1, 32'hCAFE_F00D, 32'h0BAD_C0DE};
    vecs[13] = '{1'b0, 2'b00, 4'd0,  3'd1, 32'h0BAD_C0DE, 32'h3333_4444};

    reset         = 1'b1;
    bus.sdr_width = 2'b00;
    bus.wr_req    = 1'b0;
    bus.rd_req    = 1'b0;
    bus.xfr_addr  = 4'd0;
    bus.xfr_len   = 3'd0;
    bus.a2x_wrdt  = 32'h0;
    repeat (3) @(negedge clk);
    chk("reset_state",
        {24'd0, bus.x2a_rddt, bus.req_ack, bus.busy, bus.x2a_wrstart, bus.x2a_wrnext,
         bus.x2a_wrlast, bus.x2a_rdstart, bus.x2a_rdok, bus.x2a_rdlast},
        64'd0);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].is_wr) run_write(vecs[i], 1'b0);
      else               run_read(vecs[i]);
    end

    // Both requests at once: the write wins and the read is dropped.
    run_write('{1'b1, 2'b00, 4'd2, 3'd0, 32'h0F1E_2D3C, 32'h0}, 1'b1);
    repeat (2) @(negedge clk);
    run_read('{1'b0, 2'b10, 4'd2, 3'd0, 32'h0F1E_2D3C, 32'h0});

    // Reset in the middle of an 8-bit write: addr 5 keeps its old word.
    run_write('{1'b1, 2'b00, 4'd5, 3'd0, 32'h5566_7788, 32'h0}, 1'b0);
    @(negedge clk);
    bus.sdr_width = 2'b10;
    bus.xfr_addr  = 4'd5;
    bus.xfr_len   = 3'd0;
    bus.wr_req    = 1'b1;
    #1;
    chk("rst_wr_ack", {63'd0, bus.req_ack}, 64'd1);
    @(negedge clk);
    bus.wr_req   = 1'b0;
    bus.a2x_wrdt = 32'h0000_00AA;
    @(negedge clk);
    bus.a2x_wrdt = 32'h0000_00BB;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_mid_outputs",
        {57'd0, bus.req_ack, bus.busy, bus.x2a_wrstart, bus.x2a_wrnext, bus.x2a_wrlast,
         bus.x2a_rdok, bus.x2a_rdlast},
        64'd0);
    @(negedge clk);
    reset = 1'b0;
    run_read('{1'b0, 2'b00, 4'd5, 3'd0, 32'h5566_7788, 32'h0});
    run_read('{1'b0, 2'b01, 4'd3, 3'd0, 32'hDEAD_BEEF, 32'h0});

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
